// File: rtl/parity_pkg.sv
// Shared types, mode constants and sizing helper for the parity frame checker.
package parity_pkg;

  // Running parity of the data bits accepted so far in the current frame.
  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  // Per-frame parity mode, as presented on odd_mode.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a counter that must hold 0..data_bits; the value data_bits marks the parity phase.
  function automatic int bit_idx_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Serial bit stream plus frame status between the deserialiser and error reporting.
// The err_cnt signal exists only when PARITY_ERR_CNT_EN is defined.
interface parity_frame_checker_if
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
);

  localparam int IDX_W = bit_idx_w(DATA_BITS);

  // Reject configurations the checker cannot represent.
  if (DATA_BITS < 1 || DATA_BITS > 255) begin : g_bad_data_bits
    $error("parity_frame_checker_if: DATA_BITS must be in 1..255");
  end
  if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
    $error("parity_frame_checker_if: ERR_CNT_W must be at least 1");
  end

  logic             odd_mode;
  logic             in_valid;
  logic             in_bit;
  logic             abort;
  logic             par_run;
  logic [IDX_W-1:0] bit_idx;
  logic             busy;
  logic             frame_done;
  logic             parity_err;
`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  // Upstream side: the deserialiser feeding bits in.
  modport master (
    output odd_mode, in_valid, in_bit, abort,
    input  par_run, bit_idx, busy, frame_done, parity_err
`ifdef PARITY_ERR_CNT_EN
    , err_cnt
`endif
  );

  // Checker side.
  modport slave (
    input  odd_mode, in_valid, in_bit, abort,
    output par_run, bit_idx, busy, frame_done, parity_err
`ifdef PARITY_ERR_CNT_EN
    , err_cnt
`endif
  );

endinterface

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Count enabled increments, sticking at the maximum.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Framed serial parity checker: DATA_BITS data bits followed by one parity bit.
// Mealy running parity on par_run, registered frame_done/parity_err pulse per frame.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  parity_frame_checker_if.slave bus
);

  localparam int               IDX_W      = bit_idx_w(DATA_BITS);
  localparam logic [IDX_W-1:0] PARITY_IDX = IDX_W'(DATA_BITS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             parity_phase;

  assign parity_phase = (idx_q == PARITY_IDX);

  // State register: parity state, bit position, latched mode and the frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EVEN;
      idx_q   <= '0;
      mode_q  <= PAR_EVEN;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: abort wins over a valid bit; parity phase closes the frame.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (bus.abort) begin
      state_d = EVEN;
      idx_d   = '0;
    end else if (bus.in_valid) begin
      if (!parity_phase) begin
        state_d = state_t'(state_q ^ bus.in_bit);
        idx_d   = idx_q + 1'b1;
        if (idx_q == '0) begin
          mode_d = bus.odd_mode;
        end
      end else begin
        // Total parity over data plus parity bit must equal the latched mode.
        err_d   = state_q ^ bus.in_bit ^ mode_q;
        done_d  = 1'b1;
        state_d = EVEN;
        idx_d   = '0;
      end
    end
  end

  // Mealy running parity: the current data bit is folded in, the parity bit is not.
  assign bus.par_run    = parity_phase ? state_q : (state_q ^ (bus.in_valid & bus.in_bit));
  assign bus.bit_idx    = idx_q;
  assign bus.busy       = (idx_q != '0);
  assign bus.frame_done = done_q;
  assign bus.parity_err = err_q;

`ifdef PARITY_ERR_CNT_EN
  // Failed frames counted on the edge that raises frame_done, so err_cnt moves with the pulse.
  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .clr (rst),
    .inc (done_d & err_d),
    .cnt (bus.err_cnt)
  );
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised and directed bench for parity_frame_checker against a frame-level reference model.
// Two instances share one stimulus stream: DATA_BITS=8/ERR_CNT_W=2 and DATA_BITS=1/ERR_CNT_W=3.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_BITS(8), .ERR_CNT_W(2)) if0 ();
  parity_frame_checker_if #(.DATA_BITS(1), .ERR_CNT_W(3)) if1 ();

  parity_frame_checker #(.DATA_BITS(8), .ERR_CNT_W(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  parity_frame_checker #(.DATA_BITS(1), .ERR_CNT_W(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int total = 0;
  int bad   = 0;

  // Reference model: bits received in the current frame and how many of them were ones.
  int db[2]   = '{8, 1};
  int emax[2] = '{3, 7};
  int m_cnt[2], m_ones[2], m_mode[2], m_done[2], m_perr[2], m_ecnt[2];

  logic cur_v, cur_b, cur_m, cur_a, cur_r;
  logic last_pr0;
  logic seq_pr[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ones[k] = 0; m_mode[k] = 0;
      m_done[k] = 0; m_perr[k] = 0; m_ecnt[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int total_ones;
    if (cur_r) begin
      m_cnt[k] = 0; m_ones[k] = 0; m_mode[k] = 0;
      m_done[k] = 0; m_perr[k] = 0; m_ecnt[k] = 0;
      return;
    end
    m_done[k] = 0;
    if (cur_a) begin
      m_cnt[k] = 0; m_ones[k] = 0;
    end else if (cur_v) begin
      if (m_cnt[k] < db[k]) begin
        if (m_cnt[k] == 0) m_mode[k] = int'(cur_m);
        m_ones[k] += int'(cur_b);
        m_cnt[k]++;
      end else begin
        total_ones = m_ones[k] + int'(cur_b);
        m_perr[k] = ((total_ones % 2) != m_mode[k]) ? 1 : 0;
        m_done[k] = 1;
        if (m_perr[k] == 1 && m_ecnt[k] < emax[k]) m_ecnt[k]++;
        m_cnt[k] = 0; m_ones[k] = 0;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic pr, input int idx, input logic bz,
                            input logic fd, input logic pe, input int ec);
    int exp_pr;
    if (m_cnt[k] < db[k]) exp_pr = (m_ones[k] + ((cur_v && cur_b) ? 1 : 0)) % 2;
    else                  exp_pr = m_ones[k] % 2;
    check($sformatf("u%0d par_run", k), pr, exp_pr);
    check($sformatf("u%0d bit_idx", k), idx, m_cnt[k]);
    check($sformatf("u%0d busy", k), bz, (m_cnt[k] != 0) ? 1 : 0);
    check($sformatf("u%0d frame_done", k), fd, m_done[k]);
    check($sformatf("u%0d parity_err", k), pe, m_perr[k]);
`ifdef PARITY_ERR_CNT_EN
    check($sformatf("u%0d err_cnt", k), ec, m_ecnt[k]);
`else
    if (ec != 0) check($sformatf("u%0d err_cnt", k), ec, 0);
`endif
  endtask

  // One clock: drive inputs after the falling edge, check pre-edge outputs, advance the model.
  task automatic cycle(input logic v, input logic b, input logic m, input logic a, input logic r);
    int ec0, ec1;
    cur_v = v; cur_b = b; cur_m = m; cur_a = a; cur_r = r;
    if0.in_valid = v; if0.in_bit = b; if0.odd_mode = m; if0.abort = a;
    if1.in_valid = v; if1.in_bit = b; if1.odd_mode = m; if1.abort = a;
    rst = r;
    #1;
`ifdef PARITY_ERR_CNT_EN
    ec0 = int'(if0.err_cnt);
    ec1 = int'(if1.err_cnt);
`else
    ec0 = 0;
    ec1 = 0;
`endif
    check_inst(0, if0.par_run, int'(if0.bit_idx), if0.busy, if0.frame_done, if0.parity_err, ec0);
    check_inst(1, if1.par_run, int'(if1.bit_idx), if1.busy, if1.frame_done, if1.parity_err, ec1);
    last_pr0 = if0.par_run;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  // Eight data bits MSB first, optional idle gap after each bit, then the parity bit.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic m0,
                            input logic m_rest, input int gap);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, data[7-i], (i == 0) ? m0 : m_rest, 1'b0, 1'b0);
      seq_pr[i] = last_pr0;
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, m_rest, 1'b0, 1'b0);
    end
    cycle(1'b1, par, m_rest, 1'b0, 1'b0);
  endtask

  logic exp_seq[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int   exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    cur_v = 0; cur_b = 0; cur_m = 0; cur_a = 0; cur_r = 1;
    if0.in_valid = 0; if0.in_bit = 0; if0.odd_mode = 0; if0.abort = 0;
    if1.in_valid = 0; if1.in_bit = 0; if1.odd_mode = 0; if1.abort = 0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst bit_idx", if0.bit_idx, 0);
    check("rst busy", if0.busy, 0);
    check("rst frame_done", if0.frame_done, 0);
    check("rst parity_err", if0.parity_err, 0);

    // Even mode, four ones, parity 0: clean frame and the documented running-parity sequence.
    send_frame(8'b1011_0010, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) check($sformatf("par_seq[%0d]", i), seq_pr[i], exp_seq[i]);
    check("good frame_done", if0.frame_done, 1);
    check("good parity_err", if0.parity_err, 0);

    // Same data with parity 1 in even mode is a failure.
    send_frame(8'b1011_0010, 1'b1, 1'b0, 1'b0, 0);
    check("bad frame_done", if0.frame_done, 1);
    check("bad parity_err", if0.parity_err, 1);
`ifdef PARITY_ERR_CNT_EN
    check("bad err_cnt", if0.err_cnt, 1);
`endif

    // Odd mode, no ones, parity 1 passes; mode latched at bit 0 survives a mid-frame toggle.
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 0);
    check("odd parity_err", if0.parity_err, 0);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 0);
    check("latched parity_err", if0.parity_err, 0);

    // Three idle cycles after every bit gives the same result one cycle after the parity bit.
    send_frame(8'b1011_0010, 1'b0, 1'b0, 1'b0, 3);
    check("gap frame_done", if0.frame_done, 1);
    check("gap parity_err", if0.parity_err, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gap pulse width", if0.frame_done, 0);

    // Abort at bit 5 with a valid bit drops the partial frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("abort bit_idx", if0.bit_idx, 0);
    check("abort busy", if0.busy, 0);
    check("abort frame_done", if0.frame_done, 0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    check("post-abort frame_done", if0.frame_done, 1);
    check("post-abort parity_err", if0.parity_err, 0);

    // Abort coincident with the parity bit suppresses frame_done.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("abort parity frame_done", if0.frame_done, 0);
    check("abort parity bit_idx", if0.bit_idx, 0);

    // Reset mid-frame returns every output to its reset value.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst bit_idx", if0.bit_idx, 0);
    check("midrst busy", if0.busy, 0);
    check("midrst parity_err", if0.parity_err, 0);
`ifdef PARITY_ERR_CNT_EN
    check("midrst err_cnt", if0.err_cnt, 0);
`endif

    // Five back-to-back failing frames saturate the 2-bit counter.
    for (int f = 0; f < 5; f++) begin
      send_frame(8'h00, 1'b1, 1'b0, 1'b0, 0);
      check($sformatf("sat frame %0d parity_err", f), if0.parity_err, 1);
`ifdef PARITY_ERR_CNT_EN
      check($sformatf("sat frame %0d err_cnt", f), if0.err_cnt, exp_cnt[f]);
`endif
    end

    // Random traffic with occasional aborts and resets.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
            ($urandom % 40) == 0, ($urandom % 500) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Parametrised successor of the single-bit even/odd Mealy parity checker.
- Consumes a serial bit stream framed as DATA_BITS data bits followed by one parity bit.
- Tracks running parity with a Mealy output and checks the parity bit against a per-frame even/odd mode.
- Reports a per-frame pass/fail pulse. Sits behind a serial receiver (UART-style deserialiser) ahead of the error-reporting logic.

Parameters:
DATA_BITS, 8, data bits per frame before the parity bit; legal range 1..255
ERR_CNT_W, 8, width of the saturating parity-error counter (optional feature only)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-high
odd_mode  input  1  0 = even parity expected, 1 = odd; sampled on first accepted bit of a frame
in_valid  input  1  in_bit is valid this cycle; bit accepted when high
in_bit  input  1  serial data/parity bit
abort  input  1  discard current partial frame, return to frame start
par_run  output  1  Mealy running parity of accepted data bits including the current bit
bit_idx  output  $clog2(DATA_BITS+1)  index of the next bit expected (0..DATA_BITS)
busy  output  1  high while a frame is partially received (bit_idx != 0)
frame_done  output  1  registered one-cycle pulse after the parity bit is accepted
parity_err  output  1  valid with frame_done; 1 = parity mismatch
err_cnt  output  ERR_CNT_W  saturating count of failed frames (PARITY_ERR_CNT_EN only)

Behaviour:
- Reset is synchronous and active-high; one clock. Reset values: state EVEN, bit_idx=0, busy=0, frame_done=0, parity_err=0, err_cnt=0, latched mode=0.
- States:
  - EVEN: even number of 1s accepted so far in the data phase.
  - ODD: odd number of 1s accepted so far in the data phase.
  - bit_idx separates the data phase (0..DATA_BITS-1) from the parity phase (==DATA_BITS).
- Data phase, in_valid=1: next state = state XOR in_bit; bit_idx increments.
- When bit_idx==0 and in_valid=1, odd_mode is latched into mode_q for the whole frame. Mid-frame changes of odd_mode are ignored.
- Parity phase, in_valid=1:
  - total = state XOR in_bit.
  - parity_err_next = total XOR mode_q. Even mode expects total 0; odd mode expects total 1.
  - Next cycle: frame_done=1 and parity_err=parity_err_next.
  - State returns to EVEN and bit_idx to 0 on the same edge.
- in_valid=0: state, bit_idx and mode_q hold. frame_done deasserts. parity_err holds its last value.
- par_run is combinational:
  - Data phase: state XOR (in_valid AND in_bit).
  - Parity phase: equals the data-only parity (state). The parity bit is not folded in.
- Back-to-back frames: a bit accepted the cycle after the parity bit is bit 0 of the next frame. It latches a new mode and has no bubble.
- Priority: rst > abort > in_valid.
  - abort: state=EVEN, bit_idx=0, no frame_done, no count change.
  - A bit presented in the same cycle as abort is dropped.
  - Abort during the parity-phase cycle also suppresses frame_done.
- Reset mid-frame: the partial frame is discarded and a pending frame_done is cleared.
- DATA_BITS=1: the frame is 2 bits; bit_idx width is 1.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: err_cnt increments on each frame_done with parity_err=1 and saturates at 2^ERR_CNT_W-1. Abort does not affect it; rst clears it.
- Undefined: the err_cnt port and counter logic are absent. The port list omits err_cnt, and ERR_CNT_W is unused.

Decomposition:
- Shared package parity_pkg:
  - enum state_t {EVEN=1'b0, ODD=1'b1}.
  - Mode constants PAR_EVEN=0 and PAR_ODD=1.
  - Function bit_idx_w(DATA_BITS) returning $clog2(DATA_BITS+1).
- One natural sub-module, sat_counter: parametrised width, synchronous active-high clear, increment enable, saturation. It is instantiated only under PARITY_ERR_CNT_EN.

Test Plan:
- DATA_BITS=8, even mode, data 8'b1011_0010 (four 1s) then parity 0 -> frame_done 1 cycle later, parity_err=0; par_run sequence 1,1,0,1,1,1,0,0.
- Same data, parity bit 1, even mode -> parity_err=1; err_cnt 0->1 (macro on).
- Odd mode, data 8'h00, parity 1 -> parity_err=0. Toggle odd_mode to 0 mid-frame on a second frame, data 8'h00, parity 1 -> still parity_err=0, because the mode is latched at bit 0.
- in_valid gaps of 3 cycles between every bit of a frame -> result identical to the gapless case; frame_done exactly one cycle after the parity bit.
- abort asserted at bit_idx=5 with in_valid=1 -> bit_idx=0, busy=0, no frame_done. A following full frame checks correctly. Abort coincident with the parity bit -> no frame_done.
- ERR_CNT_W=2, five consecutive bad frames back-to-back -> err_cnt 1,2,3,3,3. rst asserted mid-frame -> all outputs at reset values the next cycle.
